// File: rtl/low_fir_mac.sv
// low_fir_mac
// Multiply-accumulate FIR stage that sits right after the low-frequency
// circular queue. One frame of N_TAPS signed samples arrives while
// `sequencing` is high. Each sample is multiplied by a Q1.15 coefficient
// taken from an internal writable RAM. The products are summed, and one
// saturated 16-bit result per frame goes to the band mixer.
//
// Optional build macro: FIR_ROUND_EN
//   defined   -> round half up before the shift (add 1<<(FRAC-1))
//   undefined -> plain arithmetic shift (truncate toward -inf)
//
// Ports
//   clk         in   1       single clock, rising edge
//   rst         in   1       synchronous, active-high reset
//   smpl_in     in   16      queue sample, valid while sequencing=1
//   sequencing  in   1       one cycle per sample of a frame
//   coef_we     in   1       coefficient RAM write enable
//   coef_addr   in   10      coefficient write address
//   coef_wdata  in   16      coefficient write data, Q1.15
//   smpl_out    out  16      filtered sample, held between frames
//   smpl_vld    out  1       pulse, smpl_out updated this cycle
//   busy        out  1       frame in progress or pipeline not drained
//   frame_err   out  1       pulse, short frame aborted
//   coef_drop   out  1       pulse, coefficient write ignored (busy)
module low_fir_mac #(
    parameter int N_TAPS = 1021,
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int ADDR_W = 10,
    parameter int ACC_W  = 42,
    parameter int FRAC   = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] smpl_in,
    input  logic              sequencing,
    input  logic              coef_we,
    input  logic [ADDR_W-1:0] coef_addr,
    input  logic [COEF_W-1:0] coef_wdata,
    output logic [DATA_W-1:0] smpl_out,
    output logic              smpl_vld,
    output logic              busy,
    output logic              frame_err,
    output logic              coef_drop
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_TAPS - 1);
    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] MIN_V = -(ACC_W'(2 ** (DATA_W - 1)));

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] tap_idx, idx_nxt;
    logic              accept, abort;

    // valid bits of stages 1..3; stage 4 is smpl_vld itself
    logic [3:1]        vld_pipe;

    logic [COEF_W-1:0] coef_ram [N_TAPS];

    logic signed [DATA_W-1:0] s1_smpl;
    logic signed [COEF_W-1:0] s1_coef;
    logic [ADDR_W-1:0]        s1_idx;
    logic signed [PROD_W-1:0] s2_prod;
    logic                     s2_first, s2_last;
    logic signed [ACC_W-1:0]  acc;
    logic                     s3_last;

    logic signed [ACC_W-1:0]  acc_adj, shifted;
    logic [DATA_W-1:0]        sat_val;
    logic                     addr_ok;

    assign busy    = (state != IDLE);
    assign addr_ok = (coef_addr <= LAST_IDX);

    // ---------------- control FSM ----------------
    always_comb begin
        state_nxt = state;
        idx_nxt   = tap_idx;
        accept    = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (sequencing) begin
                    accept    = 1'b1;
                    idx_nxt   = ADDR_W'(1);
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (sequencing) begin
                    accept = 1'b1;
                    if (tap_idx == LAST_IDX) begin
                        idx_nxt   = '0;
                        state_nxt = DRAIN;
                    end else begin
                        idx_nxt = tap_idx + ADDR_W'(1);
                    end
                end else begin
                    // gap inside a frame: the partial sum is worthless
                    abort     = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            DRAIN: begin
                // a new frame may start while the previous one drains
                if (sequencing) begin
                    accept    = 1'b1;
                    idx_nxt   = ADDR_W'(1);
                    state_nxt = ACCUM;
                end else if (vld_pipe[3] && s3_last) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tap_idx   <= '0;
            vld_pipe  <= '0;
            smpl_out  <= '0;
            smpl_vld  <= 1'b0;
            frame_err <= 1'b0;
            coef_drop <= 1'b0;
        end else begin
            state     <= state_nxt;
            tap_idx   <= idx_nxt;
            vld_pipe  <= abort ? 3'b000 : {vld_pipe[2:1], accept};
            frame_err <= abort;
            coef_drop <= coef_we && addr_ok && busy;
            smpl_vld  <= vld_pipe[3] && s3_last;
            if (vld_pipe[3] && s3_last)
                smpl_out <= sat_val;
        end
    end

    // ---------------- coefficient RAM ----------------
    always_ff @(posedge clk) begin
        if (coef_we && addr_ok && !busy)
            coef_ram[coef_addr] <= coef_wdata;
        if (accept)
            s1_coef <= coef_ram[tap_idx];
    end

    // ---------------- datapath (no reset needed) ----------------
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_smpl <= smpl_in;
            s1_idx  <= tap_idx;
        end
        s2_prod  <= PROD_W'(s1_smpl) * PROD_W'(s1_coef);
        s2_first <= (s1_idx == '0);
        s2_last  <= (s1_idx == LAST_IDX);
        if (vld_pipe[2]) begin
            acc     <= s2_first ? ACC_W'(s2_prod) : acc + ACC_W'(s2_prod);
            s3_last <= s2_last;
        end
    end

    // ---------------- output scaling ----------------
    always_comb begin
`ifdef FIR_ROUND_EN
        acc_adj = acc + (ACC_W'(1) <<< (FRAC - 1));
`else
        acc_adj = acc;
`endif
        shifted = acc_adj >>> FRAC;
        if (shifted > MAX_V)
            sat_val = {1'b0, {(DATA_W-1){1'b1}}};
        else if (shifted < MIN_V)
            sat_val = {1'b1, {(DATA_W-1){1'b0}}};
        else
            sat_val = shifted[DATA_W-1:0];
    end

endmodule

// File: tb/tb_low_fir_mac.sv
module tb_low_fir_mac;

    localparam int N = 1021;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] smpl_in;
    logic        sequencing;
    logic        coef_we;
    logic [9:0]  coef_addr;
    logic [15:0] coef_wdata;
    logic [15:0] smpl_out;
    logic        smpl_vld;
    logic        busy;
    logic        frame_err;
    logic        coef_drop;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    low_fir_mac dut (
        .clk        (clk),
        .rst        (rst),
        .smpl_in    (smpl_in),
        .sequencing (sequencing),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .smpl_out   (smpl_out),
        .smpl_vld   (smpl_vld),
        .busy       (busy),
        .frame_err  (frame_err),
        .coef_drop  (coef_drop)
    );

    typedef struct {
        int          mode;     // 0: coef[k]=k+1, 1: all 7FFF
        logic [9:0]  hot_idx;
        logic [15:0] hot_val;
        logic [15:0] fill;
        logic [15:0] exp_t;    // truncating build
        logic [15:0] exp_r;    // rounding build
        string       name;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pick(input logic [15:0] t, input logic [15:0] r);
`ifdef FIR_ROUND_EN
        return r;
`else
        return t;
`endif
    endfunction

    // mode 0: ramp k+1, mode 1: all 7FFF, mode 2: coef0=4000 else 0
    task automatic load_coefs(input int mode);
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            coef_we   = 1'b1;
            coef_addr = 10'(k);
            case (mode)
                0:       coef_wdata = 16'(k + 1);
                1:       coef_wdata = 16'h7FFF;
                default: coef_wdata = (k == 0) ? 16'h4000 : 16'h0000;
            endcase
        end
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    // One full frame; optional coefficient write at cycle we_cyc (>=1).
    task automatic run_frame(input logic [9:0] hot_idx, input logic [15:0] hot_val,
                             input logic [15:0] fill, input logic [15:0] exp,
                             input string name, input int we_cyc,
                             input logic [9:0] waddr, input logic [15:0] wdata);
        for (int c = 0; c < N; c++) begin
            @(negedge clk);
            if (we_cyc >= 0 && c == we_cyc + 1)
                check({name, "_coef_drop"}, {15'd0, coef_drop}, {15'd0, (waddr < 10'(N))});
            coef_we    = (c == we_cyc);
            coef_addr  = waddr;
            coef_wdata = wdata;
            sequencing = 1'b1;
            smpl_in    = (10'(c) == hot_idx) ? hot_val : fill;
        end
        @(negedge clk);            // cycle T+1
        sequencing = 1'b0;
        coef_we    = 1'b0;
        @(negedge clk);            // T+2
        @(negedge clk);            // T+3
        check({name, "_vld_early"}, {15'd0, smpl_vld}, 16'd0);
        check({name, "_busy_drain"}, {15'd0, busy}, 16'd1);
        @(negedge clk);            // T+4
        check({name, "_vld"}, {15'd0, smpl_vld}, 16'd1);
        check({name, "_out"}, smpl_out, exp);
        check({name, "_busy_done"}, {15'd0, busy}, 16'd0);
        @(negedge clk);
        check({name, "_vld_once"}, {15'd0, smpl_vld}, 16'd0);
    endtask

    initial begin
        int cur_mode;
        int pulses;

        vecs[0] = '{0, 10'd5,    16'h7FFF, 16'h0000, 16'h0005, 16'h0006, "impulse"};
        vecs[1] = '{0, 10'd0,    16'h7FFF, 16'h0000, 16'h0000, 16'h0001, "tap0"};
        vecs[2] = '{0, 10'd1020, 16'h0100, 16'h0000, 16'h0007, 16'h0008, "lasttap"};
        vecs[3] = '{0, 10'd10,   16'hFF00, 16'h0000, 16'hFFFF, 16'h0000, "negative"};
        vecs[4] = '{1, 10'd0,    16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, "sat_pos"};
        vecs[5] = '{1, 10'd0,    16'h8000, 16'h8000, 16'h8000, 16'h8000, "sat_neg"};
        vecs[6] = '{1, 10'd0,    16'h0001, 16'h0000, 16'h0000, 16'h0001, "tiny"};

        rst = 1'b1; smpl_in = '0; sequencing = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_out",   smpl_out, 16'h0000);
        check("rst_vld",   {15'd0, smpl_vld},  16'd0);
        check("rst_busy",  {15'd0, busy},      16'd0);
        check("rst_ferr",  {15'd0, frame_err}, 16'd0);
        check("rst_cdrop", {15'd0, coef_drop}, 16'd0);
        rst = 1'b0;

        // ---- table-driven frames ----
        cur_mode = -1;
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].mode != cur_mode) begin
                load_coefs(vecs[i].mode);
                cur_mode = vecs[i].mode;
            end
            run_frame(vecs[i].hot_idx, vecs[i].hot_val, vecs[i].fill,
                      pick(vecs[i].exp_t, vecs[i].exp_r), vecs[i].name, -1, '0, '0);
        end

        // ---- short frame: abort after 500 taps ----
        load_coefs(0);
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            sequencing = 1'b1;
            smpl_in    = 16'd1000;
        end
        @(negedge clk);            // gap cycle
        sequencing = 1'b0;
        @(negedge clk);
        check("short_ferr", {15'd0, frame_err}, 16'd1);
        check("short_busy", {15'd0, busy},      16'd0);
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) check("short_ferr_once", {15'd0, frame_err}, 16'd0);
            if (smpl_vld) pulses++;
        end
        check("short_no_vld", 16'(pulses), 16'd0);
        run_frame(10'd5, 16'h7FFF, 16'h0000, pick(16'h0005, 16'h0006), "after_short", -1, '0, '0);

        // ---- coefficient protection ----
        run_frame(10'd3, 16'h7FFF, 16'h0000, pick(16'h0003, 16'h0004), "busy_wr", 10, 10'd3, 16'h4000);
        run_frame(10'd3, 16'h7FFF, 16'h0000, pick(16'h0003, 16'h0004), "busy_wr_oor", 20, 10'd1021, 16'h1234);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = 10'd1021; coef_wdata = 16'h1111;
        @(negedge clk);
        coef_we = 1'b1; coef_addr = 10'd3; coef_wdata = 16'h4000;
        check("idle_oor_drop", {15'd0, coef_drop}, 16'd0);
        @(negedge clk);
        coef_we = 1'b0;
        check("idle_wr_drop", {15'd0, coef_drop}, 16'd0);
        run_frame(10'd3, 16'h7FFF, 16'h0000, pick(16'h3FFF, 16'h4000), "idle_wr", -1, '0, '0);

        // ---- reset mid-frame at tap 300 ----
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            sequencing = 1'b1;
            smpl_in    = 16'h7FFF;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_out",  smpl_out, 16'h0000);
        check("mrst_busy", {15'd0, busy},      16'd0);
        check("mrst_vld",  {15'd0, smpl_vld},  16'd0);
        check("mrst_ferr", {15'd0, frame_err}, 16'd0);
        rst = 1'b0;
        sequencing = 1'b0;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (smpl_vld) pulses++;
        end
        check("mrst_no_vld", 16'(pulses), 16'd0);
        run_frame(10'd5, 16'h7FFF, 16'h0000, pick(16'h0005, 16'h0006), "after_rst", -1, '0, '0);

        // ---- back-to-back frames ----
        load_coefs(2);
        pulses = 0;
        for (int c = 0; c < 2 * N + 6; c++) begin
            @(negedge clk);
            if (smpl_vld) pulses++;
            if (c == N + 3) begin
                check("b2b_vld1",  {15'd0, smpl_vld}, 16'd1);
                check("b2b_out1",  smpl_out, 16'd50);
                check("b2b_busy1", {15'd0, busy}, 16'd1);
            end
            if (c == 2 * N + 3) begin
                check("b2b_vld2", {15'd0, smpl_vld}, 16'd1);
                check("b2b_out2", smpl_out, 16'd100);
            end
            sequencing = (c < 2 * N);
            smpl_in    = (c == 0) ? 16'd100 : (c == N) ? 16'd200 : 16'd0;
        end
        check("b2b_pulses", 16'(pulses), 16'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
